// File: rtl/lib_switch_onehot_fifo.sv
// lib_switch_onehot_fifo: MxN one-hot select crossbar with a FIFO per output.
// Define SWITCH_ERR_CNT_EN to add the saturating o_err_cnt select-error counter.
module lib_switch_onehot_fifo #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [M-1:0][N-1:0]       i_sel,
  input  logic [N-1:0][WIDTH-1:0]   i_data,
  input  logic [N-1:0]              i_valid,
  output logic [N-1:0]              o_ready,
  output logic [M-1:0][WIDTH-1:0]   o_data,
  output logic [M-1:0]              o_valid,
  input  logic [M-1:0]              i_ready,
  output logic [M-1:0]              o_sel_err
`ifdef SWITCH_ERR_CNT_EN
  ,
  output logic [15:0]               o_err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [M-1:0][N-1:0]     bind_m;
  logic [M-1:0]            bad_sel;
  logic [M-1:0]            full;
  logic [M-1:0]            push;
  logic [M-1:0]            pop;
  logic [M-1:0][WIDTH-1:0] wdata;
  logic [N-1:0]            bound;
  logic [N-1:0]            blocked;

  // sel & (sel-1) is non-zero only when more than one bit is set
  always_comb begin
    for (int m = 0; m < M; m++) begin
      bad_sel[m] = (i_sel[m] & (i_sel[m] - N'(1))) != '0;
      bind_m[m]  = bad_sel[m] ? '0 : i_sel[m];
    end
  end

  always_comb begin
    bound   = '0;
    blocked = '0;
    for (int j = 0; j < N; j++) begin
      for (int m = 0; m < M; m++) begin
        if (bind_m[m][j]) begin
          bound[j] = 1'b1;
          if (full[m]) blocked[j] = 1'b1;
        end
      end
    end
    o_ready = reset_n ? (bound & ~blocked) : '0;
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      wdata[m] = '0;
      for (int j = 0; j < N; j++) begin
        if (bind_m[m][j]) wdata[m] = i_data[j];
      end
      push[m] = reset_n & (|(bind_m[m] & i_valid & o_ready));
      pop[m]  = reset_n & o_valid[m] & i_ready[m];
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_fifo
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full[m]    = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_valid[m] = wr_ptr != rd_ptr;
    assign o_data[m]  = o_valid[m] ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[m]) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop[m])  rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[m]) mem[wr_ptr[AW-1:0]] <= wdata[m];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) o_sel_err <= '0;
    else          o_sel_err <= bad_sel;
  end

`ifdef SWITCH_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      o_err_cnt <= '0;
    else if ((|bad_sel) && (o_err_cnt != 16'hFFFF))
      o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lib_switch_onehot_fifo.sv
// tb_lib_switch_onehot_fifo: vector table plus queue scoreboard for the switch.
// Honours SWITCH_ERR_CNT_EN when the design is built with it.
module tb_lib_switch_onehot_fifo;
  localparam int N = 5;
  localparam int M = 5;
  localparam int W = 32;
  localparam int D = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [M-1:0][N-1:0] i_sel;
  logic [N-1:0][W-1:0] i_data;
  logic [N-1:0]        i_valid;
  logic [N-1:0]        o_ready;
  logic [M-1:0][W-1:0] o_data;
  logic [M-1:0]        o_valid;
  logic [M-1:0]        i_ready;
  logic [M-1:0]        o_sel_err;
`ifdef SWITCH_ERR_CNT_EN
  logic [15:0]         o_err_cnt;
`endif

  lib_switch_onehot_fifo #(
    .N(N), .M(M), .WIDTH(W), .DEPTH(D)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_sel    (i_sel),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sel_err(o_sel_err)
`ifdef SWITCH_ERR_CNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // scoreboard: one ring queue of expected words per output
  logic [W-1:0] mq [M][D];
  int           head [M];
  int           cnt  [M];
  logic [M-1:0] exp_err;
  logic [15:0]  ecnt;

  typedef struct {
    logic [M-1:0][N-1:0] sel;
    logic [N-1:0]        valid;
    logic [M-1:0]        rdy;
    logic [N-1:0]        eordy;
    logic [M-1:0]        eerr;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_rdy();
    logic [N-1:0] r;
    logic bnd, blk;
    r = '0;
    for (int j = 0; j < N; j++) begin
      bnd = 1'b0;
      blk = 1'b0;
      for (int m = 0; m < M; m++) begin
        if ($countones(i_sel[m]) == 1 && i_sel[m][j]) begin
          bnd = 1'b1;
          if (cnt[m] == D) blk = 1'b1;
        end
      end
      r[j] = reset_n & bnd & ~blk;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < M; m++) begin
      head[m] = 0;
      cnt[m]  = 0;
    end
    exp_err = '0;
    ecnt    = '0;
  endtask

  // inputs are already driven; check, advance the model, move to next negedge
  task automatic step();
    logic [N-1:0] er;
    #1;
    er = model_rdy();
    chk("o_ready", o_ready, er);
    for (int m = 0; m < M; m++) begin
      chk($sformatf("o_valid[%0d]", m), o_valid[m], cnt[m] != 0);
      if (cnt[m] != 0)
        chk($sformatf("o_data[%0d]", m), o_data[m], mq[m][head[m]]);
    end
    chk("o_sel_err", o_sel_err, exp_err);
`ifdef SWITCH_ERR_CNT_EN
    chk("o_err_cnt", o_err_cnt, ecnt);
`endif
    if (!reset_n) begin
      model_clear();
    end else begin
      for (int m = 0; m < M; m++) begin
        if (cnt[m] != 0 && i_ready[m]) begin
          head[m] = (head[m] + 1) % D;
          cnt[m]--;
        end
      end
      for (int m = 0; m < M; m++) begin
        if ($countones(i_sel[m]) == 1) begin
          for (int j = 0; j < N; j++) begin
            if (i_sel[m][j] && i_valid[j] && er[j]) begin
              mq[m][(head[m] + cnt[m]) % D] = i_data[j];
              cnt[m]++;
            end
          end
        end
        exp_err[m] = (i_sel[m] != '0) && ($countones(i_sel[m]) != 1);
      end
      if ((|exp_err) && ecnt != 16'hFFFF) ecnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    i_sel   = '0;
    i_valid = '0;
    i_ready = '0;
    for (int j = 0; j < N; j++) i_data[j] = $urandom;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  int sent, rx, cyc, r;
  logic [N-1:0] er0;

  initial begin
    tbl[0] = '{sel: '0, valid: '1, rdy: '0, eordy: '0, eerr: '0};
    tbl[1] = '{sel: {5'b0, 5'b0, 5'b00100, 5'b0, 5'b0},
               valid: 5'b00100, rdy: 5'b00100,
               eordy: 5'b00100, eerr: 5'b0};
    tbl[2] = '{sel: {5'b0, 5'b00010, 5'b0, 5'b0, 5'b00010},
               valid: 5'b00010, rdy: 5'b0,
               eordy: 5'b00010, eerr: 5'b0};
    tbl[3] = '{sel: {5'b00110, 5'b0, 5'b0, 5'b0, 5'b0},
               valid: '1, rdy: '0,
               eordy: 5'b0, eerr: 5'b10000};
    tbl[4] = '{sel: {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001},
               valid: '1, rdy: '1,
               eordy: 5'b11111, eerr: 5'b0};
    tbl[5] = '{sel: {5'b0, 5'b0, 5'b0, 5'b11111, 5'b00001},
               valid: '1, rdy: '0,
               eordy: 5'b00001, eerr: 5'b00010};
    tbl[6] = '{sel: {5'b0, 5'b0, 5'b01001, 5'b10000, 5'b10000},
               valid: '1, rdy: '1,
               eordy: 5'b10000, eerr: 5'b00100};

    reset_n = 1'b0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    // o_ready must stay low while reset is asserted
    i_sel[0] = 5'b00001;
    i_valid  = '1;
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      i_sel   = tbl[i].sel;
      i_valid = tbl[i].valid;
      i_ready = tbl[i].rdy;
      for (int j = 0; j < N; j++) i_data[j] = $urandom;
      #1 chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].eordy);
      step();
      idle();
      #1 chk($sformatf("tbl%0d_err", i), o_sel_err, tbl[i].eerr);
      step();
    end

    // one-cycle latency
    do_reset();
    i_sel[2] = 5'b00100; i_valid = 5'b00100;
    i_data[2] = 32'hA5; i_ready[2] = 1'b1;
    step();
    idle();
    i_ready[2] = 1'b1;
    #1 chk("lat_valid", o_valid[2], 1'b1);
    chk("lat_data", o_data[2], 32'hA5);
    step();

    // multicast to outputs 0 and 3 until full
    do_reset();
    i_sel[0] = 5'b00010; i_sel[3] = 5'b00010; i_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data[1] = 32'h100 + k;
      #1 chk($sformatf("mc_ready%0d", k), o_ready[1], 1'b1);
      step();
    end
    #1 chk("mc_full_ready", o_ready[1], 1'b0);
    step();
    idle();
    i_ready = 5'b01001;
    repeat (5) step();

    // full FIFO with a same-cycle pop
    do_reset();
    i_sel[0] = 5'b00001; i_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data[0] = 32'h200 + k;
      step();
    end
    i_ready[0] = 1'b1; i_data[0] = 32'h2AA;
    #1 chk("fp_blocked", o_ready[0], 1'b0);
    step();
    #1 chk("fp_accept", o_ready[0], 1'b1);
    step();
    idle();
    i_ready = '1;
    repeat (6) step();

    // three cycles of a bad select
    do_reset();
    i_sel[4] = 5'b00110; i_valid = '1;
    repeat (3) step();
    idle();
    repeat (2) step();

    // reset discards buffered entries
    do_reset();
    i_sel[1] = 5'b00010; i_valid[1] = 1'b1;
    repeat (2) step();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1 chk("rst_valid", o_valid[1], 1'b0);
    chk("rst_data", o_data[1], 32'h0);
    i_sel[1] = 5'b00010; i_valid[1] = 1'b1; i_data[1] = 32'h5151;
    step();
    idle();
    #1 chk("rst_push_valid", o_valid[1], 1'b1);
    chk("rst_push_data", o_data[1], 32'h5151);
    step();

    // wrap-around streaming with random backpressure
    do_reset();
    sent = 0; rx = 0; cyc = 0;
    i_sel[0] = 5'b00001;
    while ((sent < 3 * D || cnt[0] != 0) && cyc < 400) begin
      i_valid[0] = (sent < 3 * D) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_data[0]  = 32'h1000 + sent;
      i_ready[0] = 1'($urandom_range(0, 1));
      er0 = model_rdy();
      if (i_valid[0] && er0[0]) sent++;
      if (cnt[0] != 0 && i_ready[0]) rx++;
      step();
      cyc++;
    end
    chk("wrap_timeout", cyc < 400, 1'b1);
    chk("wrap_count", rx, 3 * D);

    // random traffic
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < M; m++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      i_sel[m] = 5'(1) << $urandom_range(0, N - 1);
        else if (r < 8) i_sel[m] = '0;
        else            i_sel[m] = 5'($urandom_range(0, 31));
      end
      i_valid = 5'($urandom);
      i_ready = 5'($urandom);
      for (int j = 0; j < N; j++) i_data[j] = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
